// File: rtl/grf_mp.sv
// Multi-port general register file: NRD combinational reads, NWR prioritised writes,
// optional write bypass, hardwired zero register, busy scoreboard and registered commit trace.
module grf_mp #(
  parameter int          WIDTH     = 32,
  parameter int          DEPTH     = 32,
  parameter int          AW        = $clog2(DEPTH),
  parameter int          NRD       = 2,
  parameter int          NWR       = 2,
  parameter int          BYPASS    = 1,
  parameter int          ZERO_REG  = 1,
  parameter logic [31:0] PC_OFFSET = 32'h0000_3000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NRD*AW-1:0]    ra,
  output logic [NRD*WIDTH-1:0] rd,
  output logic [NRD-1:0]       rbusy,
  input  logic [NWR-1:0]       we,
  input  logic [NWR*AW-1:0]    wa,
  input  logic [NWR*WIDTH-1:0] wd,
  input  logic [NWR*32-1:0]    wpc,
  input  logic                 issue_en,
  input  logic [AW-1:0]        issue_addr,
  output logic [NWR-1:0]       trace_valid,
  output logic [NWR*AW-1:0]    trace_addr,
  output logic [NWR*WIDTH-1:0] trace_data,
  output logic [NWR*32-1:0]    trace_pc
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Register array: ports are applied in ascending order so the highest index wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && !is_zero(wa[j*AW +: AW]))
          mem[wa[j*AW +: AW]] <= wd[j*WIDTH +: WIDTH];
      end
    end
  end

  // Scoreboard: writes clear first, then a same-edge issue re-sets (new producer wins)
  always_comb begin
    busy_nxt = busy;
    for (int j = 0; j < NWR; j++) begin
      if (we[j]) busy_nxt[wa[j*AW +: AW]] = 1'b0;
    end
    if (issue_en && !is_zero(issue_addr)) busy_nxt[issue_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy <= '0;
    else        busy <= busy_nxt;
  end

  // Combinational read with optional same-cycle bypass; busy is never bypassed
  always_comb begin
    rd    = '0;
    rbusy = '0;
    for (int i = 0; i < NRD; i++) begin
      logic [AW-1:0]    addr;
      logic [WIDTH-1:0] val;
      addr = ra[i*AW +: AW];
      val  = mem[addr];
      if (BYPASS != 0) begin
        for (int j = 0; j < NWR; j++) begin
          if (we[j] && (wa[j*AW +: AW] == addr)) val = wd[j*WIDTH +: WIDTH];
        end
      end
      if (is_zero(addr)) val = '0;
      rd[i*WIDTH +: WIDTH] = val;
      rbusy[i]             = busy[addr] && !is_zero(addr);
    end
  end

  // Commit trace, one cycle behind the write; idle ports hold their last fields
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trace_valid <= '0;
      trace_addr  <= '0;
      trace_data  <= '0;
      trace_pc    <= '0;
    end else begin
      trace_valid <= we;
      for (int j = 0; j < NWR; j++) begin
        if (we[j]) begin
          trace_addr[j*AW +: AW]       <= wa[j*AW +: AW];
          trace_data[j*WIDTH +: WIDTH] <= is_zero(wa[j*AW +: AW]) ? '0 : wd[j*WIDTH +: WIDTH];
          trace_pc[j*32 +: 32]         <= wpc[j*32 +: 32] + PC_OFFSET;
        end
      end
    end
  end

endmodule

// File: tb/tb_grf_mp.sv
// Directed bench for grf_mp: default, no-bypass and wide/shallow/single-write configurations.
module tb_grf_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  ra;
  logic [1:0]  we;
  logic [9:0]  wa;
  logic [63:0] wd;
  logic [63:0] wpc;
  logic        ien;
  logic [4:0]  iaddr;

  logic [63:0] rd_a, rd_b, td_a, td_b, tp_a, tp_b;
  logic [1:0]  rbusy_a, rbusy_b, tv_a, tv_b;
  logic [9:0]  ta_a, ta_b;

  logic [11:0]  b_ra;
  logic [191:0] b_rd;
  logic [2:0]   b_rbusy;
  logic [0:0]   b_we, b_tv;
  logic [3:0]   b_wa, b_iaddr, b_ta;
  logic [63:0]  b_wd, b_td;
  logic [31:0]  b_wpc, b_tp;
  logic         b_ien;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  grf_mp dut_a (
    .clk(clk), .reset(rst_n), .ra(ra), .rd(rd_a), .rbusy(rbusy_a),
    .we(we), .wa(wa), .wd(wd), .wpc(wpc), .issue_en(ien), .issue_addr(iaddr),
    .trace_valid(tv_a), .trace_addr(ta_a), .trace_data(td_a), .trace_pc(tp_a)
  );

  grf_mp #(.BYPASS(0)) dut_b (
    .clk(clk), .reset(rst_n), .ra(ra), .rd(rd_b), .rbusy(rbusy_b),
    .we(we), .wa(wa), .wd(wd), .wpc(wpc), .issue_en(ien), .issue_addr(iaddr),
    .trace_valid(tv_b), .trace_addr(ta_b), .trace_data(td_b), .trace_pc(tp_b)
  );

  grf_mp #(.WIDTH(64), .DEPTH(16), .NRD(3), .NWR(1)) dut_c (
    .clk(clk), .reset(rst_n), .ra(b_ra), .rd(b_rd), .rbusy(b_rbusy),
    .we(b_we), .wa(b_wa), .wd(b_wd), .wpc(b_wpc), .issue_en(b_ien), .issue_addr(b_iaddr),
    .trace_valid(b_tv), .trace_addr(b_ta), .trace_data(b_td), .trace_pc(b_tp)
  );

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1, iaddr, ra0, ra1, e_ta0;
    logic [31:0] wd0, wpc0, wd1, wpc1;
    logic        ien;
    logic [31:0] e_rd0, e_rd1, e_nb0, e_td0, e_td1, e_tpc0;
    logic [1:0]  e_rbusy, e_tv;
  } vec_t;

  vec_t tbl[$];

  task automatic addv(
    input logic [1:0] vwe, input logic [4:0] vwa0, input logic [31:0] vwd0, input logic [31:0] vwpc0,
    input logic [4:0] vwa1, input logic [31:0] vwd1, input logic [31:0] vwpc1,
    input logic vien, input logic [4:0] viaddr, input logic [4:0] vra0, input logic [4:0] vra1,
    input logic [31:0] erd0, input logic [31:0] erd1, input logic [31:0] enb0, input logic [1:0] erb,
    input logic [1:0] etv, input logic [4:0] eta0, input logic [31:0] etd0, input logic [31:0] etd1,
    input logic [31:0] etpc0);
    vec_t v;
    v.we = vwe; v.wa0 = vwa0; v.wd0 = vwd0; v.wpc0 = vwpc0;
    v.wa1 = vwa1; v.wd1 = vwd1; v.wpc1 = vwpc1;
    v.ien = vien; v.iaddr = viaddr; v.ra0 = vra0; v.ra1 = vra1;
    v.e_rd0 = erd0; v.e_rd1 = erd1; v.e_nb0 = enb0; v.e_rbusy = erb;
    v.e_tv = etv; v.e_ta0 = eta0; v.e_td0 = etd0; v.e_td1 = etd1; v.e_tpc0 = etpc0;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    we = '0; wa = '0; wd = '0; wpc = '0; ien = 1'b0; iaddr = '0; ra = '0;
  endtask

  initial begin
    idle_inputs();
    b_ra = '0; b_we = '0; b_wa = '0; b_wd = '0; b_wpc = '0; b_ien = 1'b0; b_iaddr = '0;
    rst_n = 1'b0;
    #2;
    chk("reset_rd", rd_a, 64'h0);
    chk("reset_tv", {62'h0, tv_a}, 64'h0);
    chk("reset_tpc", tp_a, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    //   we   wa0 wd0            wpc0          wa1 wd1  wpc1  ien ia ra0 ra1 rd0            rd1            nb0           rbusy tv  ta0 td0           td1    tpc0
    addv(2'b01, 3, 32'h1234_5678, 32'h10,        0, 0,    0,    0, 0, 3, 0,  32'h1234_5678, 0,             0,            2'b00, 2'b01, 3, 32'h1234_5678, 0,     32'h3010);
    addv(2'b00, 0, 0,             0,             0, 0,    0,    0, 0, 3, 3,  32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 2'b00, 2'b00, 3, 32'h1234_5678, 0,    32'h3010);
    addv(2'b11, 7, 32'hA,         32'h20,        7, 32'hB, 32'h24, 0, 0, 7, 3, 32'hB,         32'h1234_5678, 0,            2'b00, 2'b11, 7, 32'hA,        32'hB, 32'h3020);
    addv(2'b00, 0, 0,             0,             0, 0,    0,    0, 0, 7, 0,  32'hB,         0,             32'hB,        2'b00, 2'b00, 7, 32'hA,        32'hB, 32'h3020);
    addv(2'b01, 0, 32'hFFFF_FFFF, 32'h30,        0, 0,    0,    1, 0, 0, 7,  0,             32'hB,         0,            2'b00, 2'b01, 0, 0,            32'hB, 32'h3030);
    addv(2'b00, 0, 0,             0,             0, 0,    0,    1, 9, 0, 9,  0,             0,             0,            2'b00, 2'b00, 0, 0,            32'hB, 32'h3030);
    addv(2'b10, 0, 0,             0,             9, 32'h55, 32'h40, 1, 9, 9, 9, 32'h55,     32'h55,        0,            2'b11, 2'b10, 0, 0,            32'h55, 32'h3030);
    addv(2'b01, 9, 32'h66,        32'h50,        0, 0,    0,    0, 0, 9, 3,  32'h66,        32'h1234_5678, 32'h55,       2'b01, 2'b01, 9, 32'h66,       32'h55, 32'h3050);
    addv(2'b00, 0, 0,             0,             0, 0,    0,    0, 0, 9, 7,  32'h66,        32'hB,         32'h66,       2'b00, 2'b00, 9, 32'h66,       32'h55, 32'h3050);
    addv(2'b01, 1, 32'h1,         32'hFFFF_F000, 0, 0,    0,    0, 0, 1, 9,  32'h1,         32'h66,        0,            2'b00, 2'b01, 1, 32'h1,        32'h55, 32'h0000_2000);

    foreach (tbl[k]) begin
      @(negedge clk);
      we = tbl[k].we; wa = {tbl[k].wa1, tbl[k].wa0};
      wd = {tbl[k].wd1, tbl[k].wd0}; wpc = {tbl[k].wpc1, tbl[k].wpc0};
      ien = tbl[k].ien; iaddr = tbl[k].iaddr; ra = {tbl[k].ra1, tbl[k].ra0};
      #1;
      chk($sformatf("v%0d_rd0", k), rd_a[31:0], tbl[k].e_rd0);
      chk($sformatf("v%0d_rd1", k), rd_a[63:32], tbl[k].e_rd1);
      chk($sformatf("v%0d_rd0_nobypass", k), rd_b[31:0], tbl[k].e_nb0);
      chk($sformatf("v%0d_rbusy", k), rbusy_a, tbl[k].e_rbusy);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_tvalid", k), tv_a, tbl[k].e_tv);
      chk($sformatf("v%0d_taddr0", k), ta_a[4:0], tbl[k].e_ta0);
      chk($sformatf("v%0d_tdata0", k), td_a[31:0], tbl[k].e_td0);
      chk($sformatf("v%0d_tdata1", k), td_a[63:32], tbl[k].e_td1);
      chk($sformatf("v%0d_tpc0", k), tp_a[31:0], tbl[k].e_tpc0);
    end

    // Mid-cycle asynchronous reset with a loaded, busy register
    @(negedge clk);
    idle_inputs();
    we = 2'b01; wa = 10'd5; wd = 64'hDEAD_BEEF; ien = 1'b1; iaddr = 5'd5; ra = 10'd5;
    @(negedge clk);
    idle_inputs();
    ra = 10'd5;
    #1;
    chk("pre_reset_rd", rd_a[31:0], 32'hDEAD_BEEF);
    chk("pre_reset_rbusy", rbusy_a, 2'b01);
    chk("pre_reset_tvalid", tv_a, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_rd", rd_a[31:0], 32'h0);
    chk("midreset_rd_nobypass", rd_b[31:0], 32'h0);
    chk("midreset_rbusy", rbusy_a, 2'b00);
    chk("midreset_tvalid", tv_a, 2'b00);
    chk("midreset_tpc", tp_a, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    we = 2'b01; wa = 10'd2; wd = 64'h77; ra = 10'd2;
    @(posedge clk);
    #1;
    chk("first_write_after_reset", rd_b[31:0], 32'h77);
    @(negedge clk);
    idle_inputs();

    // Wide/shallow configuration, single write port, three read ports
    b_we = 1'b1; b_wa = 4'd3; b_wd = 64'h0123_4567_89AB_CDEF; b_wpc = 32'h10;
    b_ra = {4'd3, 4'd0, 4'd3};
    #1;
    chk("wide_bypass_rd0", b_rd[63:0], 64'h0123_4567_89AB_CDEF);
    chk("wide_zero_rd1", b_rd[127:64], 64'h0);
    @(posedge clk);
    #1;
    chk("wide_tvalid", {63'h0, b_tv}, 64'h1);
    chk("wide_tdata", b_td, 64'h0123_4567_89AB_CDEF);
    chk("wide_tpc", {32'h0, b_tp}, 64'h3010);
    @(negedge clk);
    b_wa = 4'd0; b_wd = 64'hFFFF_FFFF_FFFF_FFFF; b_ien = 1'b1; b_iaddr = 4'd0;
    b_ra = {4'd3, 4'd0, 4'd0};
    #1;
    chk("wide_zero_bypass", b_rd[63:0], 64'h0);
    chk("wide_stored_rd2", b_rd[191:128], 64'h0123_4567_89AB_CDEF);
    @(posedge clk);
    #1;
    chk("wide_zero_tdata", b_td, 64'h0);
    @(negedge clk);
    b_we = 1'b0; b_ien = 1'b1; b_iaddr = 4'd9; b_ra = {4'd9, 4'd0, 4'd0};
    #1;
    chk("wide_zero_never_busy", {61'h0, b_rbusy}, 64'h0);
    @(negedge clk);
    b_ien = 1'b0;
    #1;
    chk("wide_issue_busy", {61'h0, b_rbusy}, 64'h4);
    b_we = 1'b1; b_wa = 4'd9; b_wd = 64'h5;
    #1;
    chk("wide_clear_not_bypassed", {61'h0, b_rbusy}, 64'h4);
    @(negedge clk);
    b_we = 1'b0;
    #1;
    chk("wide_busy_cleared", {61'h0, b_rbusy}, 64'h0);
    chk("wide_stored_rd9", b_rd[191:128], 64'h5);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/grf_mp.md
Name: grf_mp

Overview:
- Parametrised successor to the single-write general register file.
- Configurable width and depth; NRD combinational read ports; NWR prioritised write ports with optional write-to-read bypass; hardwired-zero register; busy scoreboard for hazard/stall detection.
- Registered per-port write-trace bus replaces simulation-only print for commit logging.
- Sits between decode/issue (read, issue) and writeback (write, trace) in the multi-issue CPU core.

Parameters:
- WIDTH, 32, data width of each register.
- DEPTH, 32, number of registers (power of two, >= 2).
- AW, $clog2(DEPTH), address width (derived; do not override).
- NRD, 2, number of read ports.
- NWR, 2, number of write ports.
- BYPASS, 1, 1 = a same-cycle write is visible on read data; 0 = read returns stored value.
- ZERO_REG, 1, 1 = register 0 reads zero, ignores writes, never busy.
- PC_OFFSET, 32'h0000_3000, added to wpc to form trace_pc.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ra  in  NRD*AW  read addresses; port i = ra[i*AW +: AW].
- rd  out  NRD*WIDTH  read data; port i = rd[i*WIDTH +: WIDTH].
- rbusy  out  NRD  busy bit of the register addressed by each read port.
- we  in  NWR  write enables.
- wa  in  NWR*AW  write addresses.
- wd  in  NWR*WIDTH  write data.
- wpc  in  NWR*32  PC of the instruction committing on each write port.
- issue_en  in  1  mark issue_addr busy (instruction issued, result pending).
- issue_addr  in  AW  destination register being issued.
- trace_valid  out  NWR  per-port commit-trace strobe.
- trace_addr  out  NWR*AW  traced register address.
- trace_data  out  NWR*WIDTH  traced value actually written (0 for zero-reg writes).
- trace_pc  out  NWR*32  wpc + PC_OFFSET.

Behaviour:
- Reset (reset=0, asynchronous):
  - All registers = 0; busy[] = 0; trace_valid = 0; trace_addr/data/pc = 0.
  - Takes effect immediately, mid-cycle included.
  - First write accepted at the first rising edge after reset deasserts.
- Write:
  - On a rising edge, for each port j with we[j]=1, reg[wa[j]] <= wd[j].
  - Same address on several enabled ports: the highest index j wins.
- Zero register (ZERO_REG=1):
  - Writes to address 0 are discarded and traced with data 0.
  - Reads of address 0 return 0 regardless of BYPASS.
  - rbusy for address 0 is always 0.
- Read (combinational, zero latency):
  - rd[i] = reg[ra[i]].
  - If BYPASS=1 and some enabled write port has wa == ra[i] (and address is not zero-reg), rd[i] = wd of the highest-index such port.
- Scoreboard:
  - Issue: issue_en sets busy[issue_addr] at the edge.
  - Write: we[j] clears busy[wa[j]] at the edge.
  - Same edge, same address, issue and write: busy ends 1 (new producer wins).
  - rbusy[i] = busy[ra[i]], taken from registered state only; a clear in the current cycle is not bypassed.
- Trace (1-cycle latency):
  - At each edge: trace_valid[j] <= we[j]; trace_addr[j] <= wa[j]; trace_data[j] <= value written (0 for zero-reg); trace_pc[j] <= wpc[j] + PC_OFFSET, modulo 2^32.
  - Every enabled port is traced, including ports that lost a same-address priority conflict; their trace_data shows their own wd.
  - When trace_valid[j]=0, the other trace fields of port j hold their previous values.
- Out-of-range addresses cannot occur (DEPTH is a power of two).

Test Plan:
- Reset mid-run: load reg5=32'hDEAD_BEEF, drop reset between edges -> rd for ra=5 reads 0 immediately; trace_valid=0; busy all 0.
- Write/read with trace: we[0]=1, wa=3, wd=32'h1234_5678, wpc=32'h10 -> next cycle rd(ra=3)=32'h1234_5678; trace_valid[0]=1, trace_addr=3, trace_pc=32'h3010.
- Conflict and bypass:
  - Same cycle, port0 writes reg7=32'hA, port1 writes reg7=32'hB, ra[0]=7.
  - BYPASS=1 -> rd=32'hB in the same cycle; reg7=32'hB afterwards; both ports traced (data A and B).
  - BYPASS=0 -> rd shows the old value until the edge.
- Zero register: write reg0=32'hFFFF_FFFF -> rd(ra=0)=0, including the same-cycle bypass case; trace_data=0; issue_addr=0 leaves rbusy=0.
- Scoreboard:
  - issue reg9 -> rbusy=1 next cycle.
  - Write reg9 together with a fresh issue of reg9 -> rbusy stays 1.
  - Write reg9 alone -> rbusy=0 the following cycle.
- Parameter sweep: WIDTH=64, DEPTH=16, NRD=3, NWR=1 -> all of the above pass with the scaled widths; trace_pc is still 32-bit.
